// File: rtl/leddc_serializer.sv
// leddc_serializer
//   Feeder for the LED driver controller's serial load port. 16-bit
//   grayscale words are buffered in a small FIFO, then shifted out
//   LSB-first on DAI with DEN high, one bit per DCK, BURST_WORDS words
//   per burst. After each burst DEN stays low for at least GAP_CYCLES.
//
// Ports
//   DCK       sole clock, posedge
//   rst       asynchronous active-high reset
//   in_data   16-bit word to buffer
//   in_valid  in_data valid; pushed when in_valid && in_ready
//   in_ready  FIFO not full
//   frame_go  one-cycle burst request (honoured only when idle)
//   DAI       serial data, LSB first (registered)
//   DEN       high while DAI carries a valid bit (registered)
//   busy      high from the accepted frame_go until the gap ends
//   done      one-cycle pulse on the cycle DEN falls after the last bit
//   stall_cnt cycles spent in STALL (only with LEDDC_SER_STAT_EN)
//
// Optional feature macro: LEDDC_SER_STAT_EN adds the stall_cnt output.

module leddc_serializer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int BURST_WORDS = 256,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        DCK,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        frame_go,
    output logic        DAI,
    output logic        DEN,
    output logic        busy,
    output logic        done
`ifdef LEDDC_SER_STAT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(BURST_WORDS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STALL, GAP} state_t;

    state_t state, state_n;

    // ---------------- FIFO ----------------
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;
    logic [15:0]   rd_data;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge DCK) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge DCK or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- control ----------------
    logic [15:0]   sh;
    logic [3:0]    bit_cnt;
    logic [WW-1:0] word_cnt;
    logic [GW-1:0] gap_cnt;
    logic          go_acc, last_word, gap_end;

    assign last_word = (word_cnt == WW'(BURST_WORDS - 1));
    // GAP_CYCLES DEN-low cycles are counted after the last bit leaves DAI.
    assign gap_end   = (gap_cnt == GW'(GAP_CYCLES));

    always_ff @(posedge DCK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        go_acc  = 1'b0;
        case (state)
            IDLE: if (frame_go) begin
                state_n = LOAD;
                go_acc  = 1'b1;
            end
            LOAD: if (!empty) begin
                pop     = 1'b1;
                state_n = SHIFT;
            end else begin
                state_n = STALL;
            end
            SHIFT: if (bit_cnt == 4'd15) begin
                if (last_word)   state_n = GAP;
                else if (!empty) pop     = 1'b1;  // next word, no DEN gap
                else             state_n = STALL;
            end
            STALL: if (!empty) state_n = LOAD;
            GAP:   if (gap_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge DCK or posedge rst) begin
        if (rst) begin
            sh       <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            gap_cnt  <= '0;
            DAI      <= 1'b0;
            DEN      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            DAI  <= 1'b0;
            DEN  <= 1'b0;
            done <= 1'b0;
            if (state == SHIFT) begin
                DAI     <= sh[0];
                DEN     <= 1'b1;
                sh      <= {1'b0, sh[15:1]};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == 4'd15)
                    word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            end
            // A pop always starts a fresh word in the shifter.
            if (pop) begin
                sh      <= rd_data;
                bit_cnt <= '0;
            end
            if (state == GAP) begin
                done    <= (gap_cnt == '0);
                gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
            end
            if (go_acc)                      busy <= 1'b1;
            else if (state == GAP && gap_end) busy <= 1'b0;
        end
    end

`ifdef LEDDC_SER_STAT_EN
    always_ff @(posedge DCK or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (go_acc)
            stall_cnt <= '0;
        else if (state == STALL && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_leddc_serializer.sv
// Directed bench for leddc_serializer. Three instances with
// BURST_WORDS = 1, 4 and 3 share the clock; each has its own inputs.
module tb_leddc_serializer;

    logic        DCK;
    logic        rst      [3];
    logic [15:0] din      [3];
    logic        vld      [3];
    logic        rdy      [3];
    logic        go       [3];
    logic        dai      [3];
    logic        den      [3];
    logic        busy     [3];
    logic        done     [3];
`ifdef LEDDC_SER_STAT_EN
    logic [15:0] stall    [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    initial DCK = 1'b0;
    always #5 DCK = ~DCK;

    leddc_serializer #(.FIFO_DEPTH(16), .BURST_WORDS(1), .GAP_CYCLES(4)) u0 (
        .DCK(DCK), .rst(rst[0]), .in_data(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .frame_go(go[0]), .DAI(dai[0]), .DEN(den[0]),
        .busy(busy[0]), .done(done[0])
`ifdef LEDDC_SER_STAT_EN
        , .stall_cnt(stall[0])
`endif
    );

    leddc_serializer #(.FIFO_DEPTH(16), .BURST_WORDS(4), .GAP_CYCLES(4)) u1 (
        .DCK(DCK), .rst(rst[1]), .in_data(din[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .frame_go(go[1]), .DAI(dai[1]), .DEN(den[1]),
        .busy(busy[1]), .done(done[1])
`ifdef LEDDC_SER_STAT_EN
        , .stall_cnt(stall[1])
`endif
    );

    leddc_serializer #(.FIFO_DEPTH(16), .BURST_WORDS(3), .GAP_CYCLES(4)) u2 (
        .DCK(DCK), .rst(rst[2]), .in_data(din[2]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .frame_go(go[2]), .DAI(dai[2]), .DEN(den[2]),
        .busy(busy[2]), .done(done[2])
`ifdef LEDDC_SER_STAT_EN
        , .stall_cnt(stall[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge DCK);
        #1;
    endtask

    task automatic push(input int k, input logic [15:0] d);
        din[k] = d;
        vld[k] = 1'b1;
        tick();
        vld[k] = 1'b0;
    endtask

    task automatic go_pulse(input int k);
        go[k] = 1'b1;
        tick();
        go[k] = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] t2w [4];
        int cnt, dens, dones;
        bit seen;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; din[k] = '0; vld[k] = 1'b0; go[k] = 1'b0;
        end
        tick(); tick();
        // ---- reset state ----
        check("rst_den",   den[0],  1'b0);
        check("rst_dai",   dai[0],  1'b0);
        check("rst_busy",  busy[0], 1'b0);
        check("rst_done",  done[0], 1'b0);
        check("rst_ready", rdy[0],  1'b1);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        tick();

        // ---- 1: single word, BURST_WORDS=1 ----
        push(0, 16'hA5C3);
        go_pulse(0);                        // edge N: IDLE -> LOAD
        check("t1_busy", busy[0], 1'b1);
        tick();                             // edge N+1: LOAD pops
        check("t1_den_pre", den[0], 1'b0);
        w = 16'b1010_0101_1100_0011;        // DAI order read from bit 0 upward
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t1_den", den[0], 1'b1);
            check("t1_dai", dai[0], w[i]);
        end
        tick();
        check("t1_den_fall", den[0],  1'b0);
        check("t1_done",     done[0], 1'b1);
        check("t1_busy_gap", busy[0], 1'b1);
        tick();
        check("t1_done_1cyc", done[0], 1'b0);
        tick(); tick();
        check("t1_busy_hold", busy[0], 1'b1);
        tick();
        check("t1_busy_end", busy[0], 1'b0);

        // ---- 2: four prefilled words, BURST_WORDS=4 ----
        t2w[0] = 16'h0001; t2w[1] = 16'h8000; t2w[2] = 16'hFFFF; t2w[3] = 16'h0000;
        for (int i = 0; i < 4; i++) push(1, t2w[i]);
        go_pulse(1);
        tick();
        for (int i = 0; i < 64; i++) begin
            tick();
            w = t2w[i/16];
            check("t2_den", den[1], 1'b1);
            check("t2_dai", dai[1], w[i%16]);
        end
        tick();
        check("t2_den_fall", den[1],  1'b0);
        check("t2_done",     done[1], 1'b1);
        tick(); tick(); tick(); tick();
        check("t2_busy_end", busy[1], 1'b0);

        // ---- 3: underflow mid-burst, BURST_WORDS=3 ----
        push(2, 16'h1234);
        go_pulse(2);                        // edge N
        tick();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t3_w0_den", den[2], 1'b1);
            if (den[2]) cnt++;
        end
        tick();                             // edge N+18: first STALL cycle
        check("t3_stall_den", den[2], 1'b0);
        tick();                             // edge N+19
        check("t3_stall_busy", busy[2], 1'b1);
        push(2, 16'h5678);                  // edge N+20
        push(2, 16'h9ABC);                  // edge N+21
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (den[2]) cnt++;
            if (done[2]) begin seen = 1; break; end
        end
        check("t3_done_seen", seen, 1'b1);
        check("t3_den_total", cnt, 48);
`ifdef LEDDC_SER_STAT_EN
        // STALL occupied edges N+18..N+21
        check("t3_stall_cnt", stall[2], 16'd4);
`endif

        // ---- 4: FIFO full / push+pop, DUT with BURST_WORDS=4 ----
        for (int i = 0; i < 16; i++) begin
            din[1] = 16'h1000 + 16'(i);
            vld[1] = 1'b1;
            tick();
        end
        check("t4_full", rdy[1], 1'b0);
        din[1] = 16'hDEAD;                  // 17th offer, held off
        tick();
        check("t4_17th", rdy[1], 1'b0);
        vld[1] = 1'b0;
        go_pulse(1);                        // edge N
        check("t4_no_pop_yet", rdy[1], 1'b0);
        tick();                             // edge N+1: pop
        check("t4_pop_ready", rdy[1], 1'b1);
        for (int i = 0; i < 15; i++) tick();
        din[1] = 16'h2222;
        vld[1] = 1'b1;
        tick();                             // edge N+17: push + pop, count 15
        check("t4_pushpop", rdy[1], 1'b1);
        tick();                             // edge N+18: push only, count 16
        check("t4_refull", rdy[1], 1'b0);
        vld[1] = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy[1]) begin seen = 1; break; end
        end
        check("t4_drain", seen, 1'b1);

        // ---- 5: async reset at bit 7 of word 2 ----
        go_pulse(1);                        // edge M
        for (int i = 0; i < 41; i++) tick(); // edge M+41 shows word 2 bit 7
        check("t5_den_before", den[1], 1'b1);
        rst[1] = 1'b1;
        #1;
        check("t5_den_async",  den[1],  1'b0);
        check("t5_busy_async", busy[1], 1'b0);
        check("t5_ready",      rdy[1],  1'b1);
        tick();
        rst[1] = 1'b0;
        tick();
        push(1, 16'h8001);
        go_pulse(1);
        tick();
        w = 16'h8001;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t5_den", den[1], 1'b1);
            check("t5_dai", dai[1], w[i]);
        end
        tick();
        check("t5_stall", den[1], 1'b0);

        // ---- 6: frame_go ignored while busy, BURST_WORDS=1 ----
        push(0, 16'h0F0F);
        push(0, 16'hF0F0);
        go_pulse(0);                        // edge N
        dens = 0; dones = 0;
        for (int i = 1; i <= 60; i++) begin
            go[0] = (i == 6 || i == 20);    // N+6 in SHIFT, N+20 in GAP
            tick();
            if (den[0])  dens++;
            if (done[0]) dones++;
        end
        go[0] = 1'b0;
        check("t6_den_cycles", dens, 16);
        check("t6_done_count", dones, 1);
        check("t6_idle", busy[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
